m72_bus_decoder: RTL and testbench

Parametrised, programmable successor to the fixed PAL chip-select decoders. Holds a runtime-loadable table of up to `NUM_REGIONS` address windows, each tagged memory or I/O space with its own wait-state count. On each CPU bus cycle it latches the address and selects the lowest-index matching region. It then drives a registered one-hot chip select and runs a wait-state counter. Finally it asserts `ready` and holds the select until the cycle ends. Sits between the V30 bus interface and the ROM/RAM/video/sound/IO blocks, so game variants can be handled by reloading the table instead of editing decode logic.

---
 rtl/m72_bus_pkg.sv | 22 ++
 rtl/m72_region_table.sv | 74 +++++++
 rtl/m72_bus_decoder.sv | 136 +++++++++++++
 tb/tb_m72_bus_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/m72_bus_pkg.sv
// Shared types for the M72 programmable chip-select decoder.
// Struct fields are sized for the V30's 20-bit bus and the widest wait count; narrower instances zero-extend.
package m72_bus_pkg;

  localparam int ADDR_MAX_W = 20;
  localparam int WAIT_MAX_W = 4;

  typedef struct packed {
    logic                  en;
    logic                  io;
    logic [ADDR_MAX_W-1:0] base;
    logic [ADDR_MAX_W-1:0] mask;
    logic [WAIT_MAX_W-1:0] wait_st;
  } region_cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } bus_state_t;

endpackage

// File: rtl/m72_region_table.sv
// Runtime-loadable decode table: register array, per-region match and
// lowest-index priority encode of the matching region's index and wait count.
module m72_region_table
  import m72_bus_pkg::*;
#(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = 20,
  parameter int WAIT_W      = 4,
  parameter int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic              cfg_io,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_mask,
  input  logic [WAIT_W-1:0] cfg_wait,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_m_io,
  output logic              hit_any,
  output logic [IDX_W-1:0]  hit_idx,
  output logic [WAIT_W-1:0] hit_wait
);

  region_cfg_t            tbl_q [NUM_REGIONS];
  region_cfg_t            tbl_d [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] hit_vec;

  always_comb begin
    tbl_d = tbl_q;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        tbl_d[i].en      = cfg_en;
        tbl_d[i].io      = cfg_io;
        tbl_d[i].base    = ADDR_MAX_W'(cfg_base);
        tbl_d[i].mask    = ADDR_MAX_W'(cfg_mask);
        tbl_d[i].wait_st = WAIT_MAX_W'(cfg_wait);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) tbl_q[i] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  // Decode reads tbl_q, so a same-cycle write is only seen by the next access.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit_vec[i] = tbl_q[i].en
                && (((ADDR_W'(tbl_q[i].base) ^ bus_addr) & ADDR_W'(tbl_q[i].mask)) == '0)
                && (tbl_q[i].io == ~bus_m_io);
    end
  end

  always_comb begin
    hit_any  = |hit_vec;
    hit_idx  = '0;
    hit_wait = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_idx  = IDX_W'(i);
        hit_wait = WAIT_W'(tbl_q[i].wait_st);
      end
    end
  end

endmodule

// File: rtl/m72_bus_decoder.sv
// Programmable chip-select decoder: latches the winning region on bus_start,
// counts its wait states on ce, then holds ready and cs until bus_end.
//   state | meaning
//   IDLE  | no bus cycle; waiting for bus_start
//   WAIT  | region selected, wait counter running
//   READY | ready asserted (hit or open-bus miss) until bus_end
module m72_bus_decoder
  import m72_bus_pkg::*;
#(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = 20,
  parameter int WAIT_W      = 4,
  parameter int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   CLK_32M,
  input  logic                   reset_n,
  input  logic                   ce,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic                   cfg_en,
  input  logic                   cfg_io,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [ADDR_W-1:0]      cfg_mask,
  input  logic [WAIT_W-1:0]      cfg_wait,
  input  logic                   bus_start,
  input  logic [ADDR_W-1:0]      bus_addr,
  input  logic                   bus_m_io,
  input  logic                   bus_end,
  output logic [NUM_REGIONS-1:0] cs,
  output logic [IDX_W-1:0]       hit_idx,
  output logic                   ready,
  output logic                   miss,
  output logic                   busy
);

  logic                   tbl_hit;
  logic [IDX_W-1:0]       tbl_idx;
  logic [WAIT_W-1:0]      tbl_wait;

  bus_state_t             state_q;
  logic [NUM_REGIONS-1:0] cs_q;
  logic [IDX_W-1:0]       idx_q;
  logic [WAIT_W-1:0]      cnt_q;
  logic                   ready_q;
  logic                   miss_q;
  logic                   busy_q;

  m72_region_table #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .WAIT_W      (WAIT_W),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk      (CLK_32M),
    .rst_n    (reset_n),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_en   (cfg_en),
    .cfg_io   (cfg_io),
    .cfg_base (cfg_base),
    .cfg_mask (cfg_mask),
    .cfg_wait (cfg_wait),
    .bus_addr (bus_addr),
    .bus_m_io (bus_m_io),
    .hit_any  (tbl_hit),
    .hit_idx  (tbl_idx),
    .hit_wait (tbl_wait)
  );

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cs_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      miss_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus_start) begin
            busy_q <= 1'b1;
            if (tbl_hit) begin
              idx_q <= tbl_idx;
              cnt_q <= tbl_wait;
              cs_q  <= NUM_REGIONS'(1) << tbl_idx;
              if (tbl_wait == '0) begin
                state_q <= READY;
                ready_q <= 1'b1;
              end else begin
                state_q <= WAIT;
              end
            end else begin
              // Open bus: complete the cycle with no select so the CPU never stalls.
              idx_q   <= '0;
              miss_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= READY;
            end
          end
        end
        WAIT: begin
          if (bus_end) begin
            state_q <= IDLE;
            cs_q    <= '0;
            busy_q  <= 1'b0;
          end else if (ce) begin
            cnt_q <= cnt_q - WAIT_W'(1);
            if (cnt_q == WAIT_W'(1)) begin
              state_q <= READY;
              ready_q <= 1'b1;
            end
          end
        end
        READY: begin
          if (bus_end) begin
            state_q <= IDLE;
            cs_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cs      = cs_q;
  assign hit_idx = idx_q;
  assign ready   = ready_q;
  assign miss    = miss_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_m72_bus_decoder.sv
// Directed plus randomized bench for m72_bus_decoder against a table-level
// reference model of the decode rules and wait-state timing.
module tb_m72_bus_decoder;

  localparam int N  = 8;
  localparam int AW = 20;
  localparam int WW = 4;
  localparam int IW = 3;

  logic          CLK_32M = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce = 1'b1;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic          cfg_en = 1'b0;
  logic          cfg_io = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_mask = '0;
  logic [WW-1:0] cfg_wait = '0;
  logic          bus_start = 1'b0;
  logic [AW-1:0] bus_addr = '0;
  logic          bus_m_io = 1'b0;
  logic          bus_end = 1'b0;
  logic [N-1:0]  cs;
  logic [IW-1:0] hit_idx;
  logic          ready, miss, busy;

  m72_bus_decoder #(.NUM_REGIONS(N), .ADDR_W(AW), .WAIT_W(WW)) dut (
    .CLK_32M(CLK_32M), .reset_n(reset_n), .ce(ce),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_io(cfg_io),
    .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_wait(cfg_wait),
    .bus_start(bus_start), .bus_addr(bus_addr), .bus_m_io(bus_m_io), .bus_end(bus_end),
    .cs(cs), .hit_idx(hit_idx), .ready(ready), .miss(miss), .busy(busy)
  );

  always #5 CLK_32M = ~CLK_32M;

  // Reference table
  bit            m_en   [N];
  bit            m_io   [N];
  logic [AW-1:0] m_base [N];
  logic [AW-1:0] m_mask [N];
  int            m_wait [N];

  bit            pend = 1'b0;
  int            p_idx, p_wait;
  bit            p_en, p_io;
  logic [AW-1:0] p_base, p_mask;

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  function automatic int decode(input logic [AW-1:0] a, input bit mio);
    for (int i = 0; i < N; i++)
      if (m_en[i] && ((a & m_mask[i]) == (m_base[i] & m_mask[i])) && (m_io[i] == !mio))
        return i;
    return -1;
  endfunction

  task automatic drive_cfg(input int idx, input bit en, input bit io,
                           input logic [AW-1:0] base, input logic [AW-1:0] mask, input int w);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_en = en; cfg_io = io;
    cfg_base = base; cfg_mask = mask; cfg_wait = WW'(w);
    pend = 1'b1; p_idx = idx; p_en = en; p_io = io; p_base = base; p_mask = mask; p_wait = w;
  endtask

  task automatic commit();
    if (pend) begin
      m_en[p_idx] = p_en; m_io[p_idx] = p_io; m_base[p_idx] = p_base;
      m_mask[p_idx] = p_mask; m_wait[p_idx] = p_wait;
      pend = 1'b0;
    end
    cfg_we = 1'b0;
  endtask

  task automatic write_region(input int idx, input bit en, input bit io,
                              input logic [AW-1:0] base, input logic [AW-1:0] mask, input int w);
    drive_cfg(idx, en, io, base, mask, w);
    tick();
    commit();
  endtask

  // ce_mode: 0 = ce high, 1 = low on first WAIT cycle then alternating, 2 = random.
  // abort_at: WAIT cycle index on which bus_end is pulsed (-1 = never).
  task automatic run_cycle(input logic [AW-1:0] addr, input bit mio, input int ce_mode,
                           input int abort_at, input int hold, input bit mid_wr);
    int idx, rem, n;
    logic [N-1:0] ecs;
    bit ce_v;
    idx = decode(addr, mio);
    rem = (idx >= 0) ? m_wait[idx] : 0;
    ecs = (idx >= 0) ? (N'(1) << idx) : '0;
    bus_start = 1'b1; bus_addr = addr; bus_m_io = mio;
    tick();
    commit();
    bus_start = 1'b0;
    check("cs_start", 32'(cs), 32'(ecs));
    check("busy_start", 32'(busy), 32'd1);
    check("miss_start", 32'(miss), (idx < 0) ? 32'd1 : 32'd0);
    if (idx >= 0) check("hit_idx", 32'(hit_idx), 32'(idx));
    n = 0;
    while (1) begin
      check("cs_wait", 32'(cs), 32'(ecs));
      check("ready_timing", 32'(ready), (rem == 0) ? 32'd1 : 32'd0);
      if (rem == 0 || n > 200) break;
      if (n == abort_at) begin
        bus_end = 1'b1;
        tick();
        bus_end = 1'b0;
        check("abort_cs", 32'(cs), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        ce = 1'b1;
        return;
      end
      if (mid_wr && n == 0 && idx >= 0)
        drive_cfg(idx, 1'b1, m_io[idx], m_base[idx], m_mask[idx], 0);
      ce_v = (ce_mode == 0) ? 1'b1 : (ce_mode == 1) ? (n % 2 == 1) : 1'($urandom_range(0, 1));
      ce = ce_v;
      tick();
      commit();
      if (ce_v) rem--;
      n++;
    end
    for (int h = 0; h < hold; h++) begin
      ce = 1'($urandom_range(0, 1));
      tick();
      check("hold_cs", 32'(cs), 32'(ecs));
      check("hold_ready", 32'(ready), 32'd1);
      check("miss_pulse", 32'(miss), 32'd0);
    end
    bus_end = 1'b1;
    tick();
    bus_end = 1'b0;
    ce = 1'b1;
    check("end_cs", 32'(cs), 32'd0);
    check("end_ready", 32'(ready), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_io[i] = 0; m_base[i] = '0; m_mask[i] = '0; m_wait[i] = 0;
    end
    tick(); tick();
    check("rst_cs", 32'(cs), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    check("rst_idx", 32'(hit_idx), 32'd0);
    reset_n = 1'b1;
    tick();

    write_region(0, 1, 0, 20'h00000, 20'hC0000, 0);
    run_cycle(20'h12345, 1, 0, -1, 2, 0);

    write_region(2, 1, 1, 20'h00040, 20'h000C0, 3);
    run_cycle(20'h00042, 0, 0, -1, 1, 0);
    run_cycle(20'h00042, 0, 1, -1, 1, 0);

    write_region(1, 1, 0, 20'hC8000, 20'hFF000, 1);
    write_region(3, 1, 0, 20'hC0000, 20'hF0000, 0);
    run_cycle(20'hC8000, 1, 0, -1, 1, 0);

    run_cycle(20'hA0000, 1, 0, -1, 1, 0);

    drive_cfg(0, 1, 0, 20'hA0000, 20'hF0000, 2);
    run_cycle(20'h12345, 1, 0, -1, 1, 0);
    run_cycle(20'hA1234, 1, 0, -1, 1, 0);
    run_cycle(20'h12345, 1, 0, -1, 1, 0);

    write_region(5, 1, 0, 20'h50000, 20'hF0000, 5);
    run_cycle(20'h5ABCD, 1, 0, 2, 0, 0);

    run_cycle(20'h00042, 0, 0, -1, 1, 1);
    run_cycle(20'h00042, 0, 0, -1, 1, 0);

    write_region(6, 1, 1, 20'h00100, 20'hFFF00, 15);
    run_cycle(20'h00180, 0, 0, -1, 1, 0);

    // Asynchronous reset in the middle of a wait sequence
    bus_start = 1'b1; bus_addr = 20'h5ABCD; bus_m_io = 1'b1;
    tick();
    bus_start = 1'b0;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_cs", 32'(cs), 32'd0);
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_idx", 32'(hit_idx), 32'd0);
    for (int i = 0; i < N; i++) m_en[i] = 0;
    tick();
    reset_n = 1'b1;
    tick();
    run_cycle(20'h5ABCD, 1, 0, -1, 1, 0);

    for (int t = 0; t < 40; t++) begin
      int k;
      logic [AW-1:0] a;
      bit mio;
      k = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1) begin
        drive_cfg(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom),
                  AW'($urandom) & 20'hF0000, $urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) begin
          tick();
          commit();
        end
      end
      k = $urandom_range(0, N - 1);
      if ($urandom_range(0, 2) != 0) begin
        a   = m_base[k] ^ (AW'($urandom) & ~m_mask[k]);
        mio = !m_io[k];
      end else begin
        a   = AW'($urandom);
        mio = 1'($urandom_range(0, 1));
      end
      run_cycle(a, mio, $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1,
                $urandom_range(0, 2), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
